// File: rtl/lu_row_store_pkg.sv
`default_nettype none
// ============================================================================
//  lu_pkg : shared types and constants for the LU engine row store
//  Revision: 1.0
// ============================================================================
package lu_pkg;

    localparam int ELEM_W_DEFAULT = 128;

    typedef enum logic [1:0] {
        HOST   = 2'd0,
        ENGINE = 2'd1,
        DRAIN  = 2'd2
    } row_owner_t;

    // Complex element packed as {imag, real}, IEEE-754 doubles.
    typedef logic [127:0] elem_t;

    localparam elem_t ONE_C = {64'b0, 64'h3ff0000000000000};

endpackage
`default_nettype wire

// File: rtl/lu_row_store_if.sv
`default_nettype none
// ============================================================================
//  lu_row_store_if : engine and host port bundle of the row store
//  Revision: 1.0
// ============================================================================
interface lu_row_store_if
    import lu_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter int ELEM_W = ELEM_W_DEFAULT
);
    localparam int AW    = $clog2(SIZE);
    localparam int ROW_W = SIZE * ELEM_W;

    logic             eng_busy_i;
    logic [AW-1:0]    eng_rd_addr_i;
    logic             eng_rd_addr_valid_i;
    logic [ROW_W-1:0] eng_row_o;
    logic [AW-1:0]    eng_row_addr_o;
    logic             eng_row_valid_o;
    logic [ROW_W-1:0] eng_wr_row_i;
    logic [AW-1:0]    eng_wr_addr_i;
    logic             eng_wr_valid_i;
    logic             eng_wr_ready_o;
    logic [ROW_W-1:0] host_wr_row_i;
    logic [AW-1:0]    host_wr_addr_i;
    logic             host_wr_valid_i;
    logic             host_wr_ready_o;
    logic [AW-1:0]    host_rd_addr_i;
    logic             host_rd_req_valid_i;
    logic             host_rd_req_ready_o;
    logic [ROW_W-1:0] host_rd_row_o;
    logic             host_rd_valid_o;
    logic             host_rd_ready_i;
    row_owner_t       owner_o;
    logic [SIZE-1:0]  written_mask_o;

    modport slave (
        input  eng_busy_i, eng_rd_addr_i, eng_rd_addr_valid_i,
               eng_wr_row_i, eng_wr_addr_i, eng_wr_valid_i,
               host_wr_row_i, host_wr_addr_i, host_wr_valid_i,
               host_rd_addr_i, host_rd_req_valid_i, host_rd_ready_i,
        output eng_row_o, eng_row_addr_o, eng_row_valid_o, eng_wr_ready_o,
               host_wr_ready_o, host_rd_req_ready_o, host_rd_row_o,
               host_rd_valid_o, owner_o, written_mask_o
    );

    modport master (
        output eng_busy_i, eng_rd_addr_i, eng_rd_addr_valid_i,
               eng_wr_row_i, eng_wr_addr_i, eng_wr_valid_i,
               host_wr_row_i, host_wr_addr_i, host_wr_valid_i,
               host_rd_addr_i, host_rd_req_valid_i, host_rd_ready_i,
        input  eng_row_o, eng_row_addr_o, eng_row_valid_o, eng_wr_ready_o,
               host_wr_ready_o, host_rd_req_ready_o, host_rd_row_o,
               host_rd_valid_o, owner_o, written_mask_o
    );

endinterface
`default_nettype wire

// File: rtl/lu_row_store_read_pipe.sv
`default_nettype none
// ============================================================================
//  row_read_pipe : fixed-latency shift pipe of {valid, addr, row}, no stall
//  Revision: 1.0
// ============================================================================
module row_read_pipe
    import lu_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int SIZE   = 16,
    parameter int ELEM_W = ELEM_W_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    input  logic [$clog2(SIZE)-1:0]  req_addr_i,
    input  logic [SIZE*ELEM_W-1:0]   req_row_i,
    output logic                     rsp_valid_o,
    output logic [$clog2(SIZE)-1:0]  rsp_addr_o,
    output logic [SIZE*ELEM_W-1:0]   rsp_row_o,
    output logic                     busy_o
);
    localparam int AW    = $clog2(SIZE);
    localparam int ROW_W = SIZE * ELEM_W;

    logic [RD_LAT-1:0] valid_q, valid_d;
    logic [AW-1:0]     addr_q [RD_LAT];
    logic [AW-1:0]     addr_d [RD_LAT];
    logic [ROW_W-1:0]  row_q  [RD_LAT];
    logic [ROW_W-1:0]  row_d  [RD_LAT];

    // Payload only moves with a valid entry, so the last stage holds its value.
    always_comb begin
        valid_d    = valid_q;
        addr_d     = addr_q;
        row_d      = row_q;
        valid_d[0] = req_valid_i;
        if (req_valid_i) begin
            addr_d[0] = req_addr_i;
            row_d[0]  = req_row_i;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) begin
                addr_d[i] = addr_q[i-1];
                row_d[i]  = row_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_q[i] <= '0;
                row_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
        end
    end

    assign rsp_valid_o = valid_q[RD_LAT-1];
    assign rsp_addr_o  = addr_q[RD_LAT-1];
    assign rsp_row_o   = row_q[RD_LAT-1];
    assign busy_o      = |valid_q;

endmodule
`default_nettype wire

// File: rtl/lu_row_store.sv
`default_nettype none
// ============================================================================
//  lu_row_store : row-organised complex matrix store shared by host and engine
//  Revision: 1.0
// ============================================================================
module lu_row_store
    import lu_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter int ELEM_W = ELEM_W_DEFAULT,
    parameter int RD_LAT = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    lu_row_store_if.slave bus
);
    localparam int AW    = $clog2(SIZE);
    localparam int ROW_W = SIZE * ELEM_W;

    logic [ROW_W-1:0] mem_q [SIZE];
    row_owner_t       owner_q;
    logic             host_rd_valid_q, host_rd_valid_d;
    logic [ROW_W-1:0] host_rd_row_q, host_rd_row_d;
    logic [SIZE-1:0]  mask_q, mask_d;

    logic             eng_rd_in, eng_wr_in, host_wr_in, host_rd_in;
    logic             eng_rd_acc, eng_wr_acc, host_wr_acc, host_rd_acc;
    logic             take_own, pipe_busy, mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [ROW_W-1:0] mem_wdata, issue_row;

    // Range checks only matter when SIZE leaves unused address codes.
    if ((1 << AW) == SIZE) begin : g_full_range
        assign eng_rd_in  = 1'b1;
        assign eng_wr_in  = 1'b1;
        assign host_wr_in = 1'b1;
        assign host_rd_in = 1'b1;
    end else begin : g_partial_range
        assign eng_rd_in  = (32'(bus.eng_rd_addr_i)  < SIZE);
        assign eng_wr_in  = (32'(bus.eng_wr_addr_i)  < SIZE);
        assign host_wr_in = (32'(bus.host_wr_addr_i) < SIZE);
        assign host_rd_in = (32'(bus.host_rd_addr_i) < SIZE);
    end

    assign bus.host_wr_ready_o     = (owner_q == HOST);
    assign bus.host_rd_req_ready_o = (owner_q == HOST) & ~host_rd_valid_q;
    assign bus.eng_wr_ready_o      = (owner_q == ENGINE);

    assign eng_rd_acc  = (owner_q == ENGINE) & bus.eng_rd_addr_valid_i;
    assign eng_wr_acc  = bus.eng_wr_valid_i & bus.eng_wr_ready_o;
    assign host_wr_acc = bus.host_wr_valid_i & bus.host_wr_ready_o;
    assign host_rd_acc = bus.host_rd_req_valid_i & bus.host_rd_req_ready_o;
    assign take_own    = (owner_q == HOST) & bus.eng_busy_i & ~host_rd_valid_q;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.host_wr_addr_i;
        mem_wdata = bus.host_wr_row_i;
        if (eng_wr_acc) begin
            mem_we    = eng_wr_in;
            mem_waddr = bus.eng_wr_addr_i;
            mem_wdata = bus.eng_wr_row_i;
        end else if (host_wr_acc) begin
            mem_we    = host_wr_in;
        end

        // A same-cycle engine write to the read address forwards its data.
        issue_row = '0;
        if (eng_wr_acc && eng_wr_in && (bus.eng_wr_addr_i == bus.eng_rd_addr_i))
            issue_row = bus.eng_wr_row_i;
        else if (eng_rd_in)
            issue_row = mem_q[bus.eng_rd_addr_i];

        mask_d = take_own ? '0 : mask_q;
        if (eng_wr_acc && eng_wr_in)
            mask_d[bus.eng_wr_addr_i] = 1'b1;

        host_rd_valid_d = host_rd_valid_q;
        host_rd_row_d   = host_rd_row_q;
        if (host_rd_acc) begin
            host_rd_valid_d = 1'b1;
            host_rd_row_d   = host_rd_in ? mem_q[bus.host_rd_addr_i] : '0;
        end else if (host_rd_valid_q && bus.host_rd_ready_i) begin
            host_rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            host_rd_valid_q <= 1'b0;
            host_rd_row_q   <= '0;
            mask_q          <= '0;
        end else begin
            host_rd_valid_q <= host_rd_valid_d;
            host_rd_row_q   <= host_rd_row_d;
            mask_q          <= mask_d;
        end
    end

    // Ownership: the host hands over only with no unload in progress, and the
    // engine gives back only once its reads have drained.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= HOST;
        end else begin
            case (owner_q)
                HOST:    if (take_own)            owner_q <= ENGINE;
                ENGINE:  if (!bus.eng_busy_i)     owner_q <= DRAIN;
                DRAIN:   if (bus.eng_busy_i)      owner_q <= ENGINE;
                         else if (!pipe_busy)     owner_q <= HOST;
                default:                          owner_q <= HOST;
            endcase
        end
    end

    assign bus.owner_o         = owner_q;
    assign bus.written_mask_o  = mask_q;
    assign bus.host_rd_valid_o = host_rd_valid_q;
    assign bus.host_rd_row_o   = host_rd_row_q;

    row_read_pipe #(
        .RD_LAT (RD_LAT),
        .SIZE   (SIZE),
        .ELEM_W (ELEM_W)
    ) u_read_pipe (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (eng_rd_acc),
        .req_addr_i  (bus.eng_rd_addr_i),
        .req_row_i   (issue_row),
        .rsp_valid_o (bus.eng_row_valid_o),
        .rsp_addr_o  (bus.eng_row_addr_o),
        .rsp_row_o   (bus.eng_row_o),
        .busy_o      (pipe_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_lu_row_store.sv
`default_nettype none
// ============================================================================
//  tb_lu_row_store : directed scoreboard bench for lu_row_store (RD_LAT = 2)
//  Revision: 1.0
// ============================================================================
module tb_lu_row_store;
    import lu_pkg::*;

    localparam int SIZE   = 16;
    localparam int ELEM_W = 128;
    localparam int RD_LAT = 2;
    localparam int ROW_W  = SIZE * ELEM_W;

    typedef logic [ROW_W-1:0] row_t;
    typedef struct {
        logic [3:0] addr;
        row_t       row;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;
    exp_t sb[$];
    exp_t mon_e;
    row_t model [SIZE];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lu_row_store_if #(.SIZE(SIZE), .ELEM_W(ELEM_W)) bus ();

    lu_row_store #(
        .SIZE   (SIZE),
        .ELEM_W (ELEM_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(string tag, row_t obs, row_t exp);
        int bad = 0;
        for (int i = SIZE - 1; i >= 0; i--)
            if (obs[i*ELEM_W +: ELEM_W] !== exp[i*ELEM_W +: ELEM_W]) bad = i;
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: element %0d observed %h expected %h", tag, bad,
                   obs[bad*ELEM_W +: ELEM_W], exp[bad*ELEM_W +: ELEM_W]);
        end
    endtask

    function automatic row_t pat(int k);
        row_t r;
        for (int i = 0; i < SIZE; i++) r[i*ELEM_W +: ELEM_W] = {64'(k), 64'(i + 1)};
        return r;
    endfunction

    function automatic row_t fill(elem_t e);
        row_t r;
        for (int i = 0; i < SIZE; i++) r[i*ELEM_W +: ELEM_W] = e;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic eng_read(logic [3:0] a, row_t exp_row);
        bus.eng_rd_addr_i       = a;
        bus.eng_rd_addr_valid_i = 1'b1;
        sb.push_back('{addr: a, row: exp_row, cyc: cyc + RD_LAT});
    endtask

    task automatic host_read(logic [3:0] a, string tag);
        bus.host_rd_addr_i      = a;
        bus.host_rd_req_valid_i = 1'b1;
        bus.host_rd_ready_i     = 1'b0;
        step();
        bus.host_rd_req_valid_i = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, 128'(bus.host_rd_valid_o), 128'd1);
        chk_row({tag, "_row"}, bus.host_rd_row_o, model[a]);
        bus.host_rd_ready_i = 1'b1;
        step();
        bus.host_rd_ready_i = 1'b0;
    endtask

    // Scoreboard side: every engine response must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && bus.eng_row_valid_o === 1'b1) begin
            chk("rsp_expected", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("rsp_tag", 128'(bus.eng_row_addr_o), 128'(mon_e.addr));
                chk("rsp_cycle", 128'(cyc), 128'(mon_e.cyc));
                chk_row("rsp_row", bus.eng_row_o, mon_e.row);
            end
        end
    end

    initial begin
        bus.eng_busy_i = 1'b0;          bus.eng_rd_addr_i = '0;
        bus.eng_rd_addr_valid_i = 1'b0; bus.eng_wr_row_i = '0;
        bus.eng_wr_addr_i = '0;         bus.eng_wr_valid_i = 1'b0;
        bus.host_wr_row_i = '0;         bus.host_wr_addr_i = '0;
        bus.host_wr_valid_i = 1'b0;     bus.host_rd_addr_i = '0;
        bus.host_rd_req_valid_i = 1'b0; bus.host_rd_ready_i = 1'b0;

        // Reset state
        repeat (2) step();
        @(negedge clk);
        chk("rst_owner", 128'(bus.owner_o), 128'(HOST));
        chk("rst_eng_valid", 128'(bus.eng_row_valid_o), 128'd0);
        chk("rst_eng_tag", 128'(bus.eng_row_addr_o), 128'd0);
        chk("rst_host_valid", 128'(bus.host_rd_valid_o), 128'd0);
        chk("rst_mask", 128'(bus.written_mask_o), 128'd0);
        chk("rst_host_wr_ready", 128'(bus.host_wr_ready_o), 128'd1);
        chk("rst_host_rd_ready", 128'(bus.host_rd_req_ready_o), 128'd1);
        chk("rst_eng_wr_ready", 128'(bus.eng_wr_ready_o), 128'd0);
        step();
        rst_n = 1'b1;

        // Host load of every row
        for (int r = 0; r < SIZE; r++) begin
            model[r] = (r == 3) ? pat(0) : (r == 8) ? fill(ONE_C) : pat(r);
            bus.host_wr_addr_i  = 4'(r);
            bus.host_wr_row_i   = model[r];
            bus.host_wr_valid_i = 1'b1;
            step();
        end
        bus.host_wr_valid_i = 1'b0;

        // Host unload of row 3, held until ready
        bus.host_rd_addr_i      = 4'd3;
        bus.host_rd_req_valid_i = 1'b1;
        step();
        bus.host_rd_req_valid_i = 1'b0;
        @(negedge clk);
        chk("hrd_valid", 128'(bus.host_rd_valid_o), 128'd1);
        chk_row("hrd_row", bus.host_rd_row_o, model[3]);
        chk("hrd_req_ready_busy", 128'(bus.host_rd_req_ready_o), 128'd0);
        step();
        @(negedge clk);
        chk("hrd_hold_valid", 128'(bus.host_rd_valid_o), 128'd1);
        chk_row("hrd_hold_row", bus.host_rd_row_o, model[3]);
        bus.host_rd_ready_i = 1'b1;
        step();
        bus.host_rd_ready_i = 1'b0;
        @(negedge clk);
        chk("hrd_fall", 128'(bus.host_rd_valid_o), 128'd0);
        chk("hrd_req_ready_again", 128'(bus.host_rd_req_ready_o), 128'd1);
        step();

        // Host write coincident with busy rise lands; later host writes do not
        bus.eng_busy_i      = 1'b1;
        bus.host_wr_valid_i = 1'b1;
        bus.host_wr_addr_i  = 4'd2;
        bus.host_wr_row_i   = pat(200);
        model[2]            = pat(200);
        step();
        bus.host_wr_addr_i  = 4'd9;
        bus.host_wr_row_i   = pat(900);
        @(negedge clk);
        chk("own_engine", 128'(bus.owner_o), 128'(ENGINE));
        chk("own_host_wr_ready", 128'(bus.host_wr_ready_o), 128'd0);
        chk("own_host_rd_ready", 128'(bus.host_rd_req_ready_o), 128'd0);
        chk("own_eng_wr_ready", 128'(bus.eng_wr_ready_o), 128'd1);
        chk("own_mask", 128'(bus.written_mask_o), 128'd0);
        step();
        bus.host_wr_valid_i = 1'b0;

        // Streaming engine reads
        eng_read(4'd5, model[5]); step();
        eng_read(4'd6, model[6]); step();
        eng_read(4'd7, model[7]); step();
        eng_read(4'd2, model[2]); step();
        eng_read(4'd9, model[9]); step();
        bus.eng_rd_addr_valid_i = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("idle_valid", 128'(bus.eng_row_valid_o), 128'd0);
        chk("idle_tag_hold", 128'(bus.eng_row_addr_o), 128'd9);
        chk_row("idle_row_hold", bus.eng_row_o, model[9]);
        step();

        // Bypass, then a later write that must not reach the in-flight read
        bus.eng_wr_valid_i = 1'b1;
        bus.eng_wr_addr_i  = 4'd4;
        bus.eng_wr_row_i   = fill({32{4'hA}});
        eng_read(4'd4, fill({32{4'hA}}));
        step();
        bus.eng_rd_addr_valid_i = 1'b0;
        bus.eng_wr_row_i   = fill({32{4'h5}});
        model[4]           = fill({32{4'h5}});
        step();
        bus.eng_wr_valid_i = 1'b0;
        @(negedge clk);
        chk("byp_mask", 128'(bus.written_mask_o), 128'h0010);
        repeat (3) step();

        // Drain with two reads in flight
        eng_read(4'd1, model[1]); step();
        eng_read(4'd4, model[4]); step();
        bus.eng_rd_addr_valid_i = 1'b0;
        bus.eng_busy_i          = 1'b0;
        @(negedge clk);
        chk("drn_still_engine", 128'(bus.owner_o), 128'(ENGINE));
        step();
        @(negedge clk);
        chk("drn_first", 128'(bus.owner_o), 128'(DRAIN));
        step();
        @(negedge clk);
        chk("drn_second", 128'(bus.owner_o), 128'(DRAIN));
        step();
        @(negedge clk);
        chk("drn_host", 128'(bus.owner_o), 128'(HOST));

        // Re-entry clears the mask; new writes set their bits
        bus.eng_busy_i = 1'b1;
        step();
        @(negedge clk);
        chk("re_owner", 128'(bus.owner_o), 128'(ENGINE));
        chk("re_mask_clear", 128'(bus.written_mask_o), 128'd0);
        bus.eng_wr_valid_i = 1'b1;
        bus.eng_wr_addr_i  = 4'd0;
        bus.eng_wr_row_i   = pat(1000);
        model[0]           = pat(1000);
        step();
        bus.eng_wr_addr_i  = 4'd15;
        bus.eng_wr_row_i   = pat(1500);
        model[15]          = pat(1500);
        step();
        bus.eng_wr_valid_i = 1'b0;
        @(negedge clk);
        chk("re_mask", 128'(bus.written_mask_o), 128'h8001);
        step();

        // Asynchronous reset with reads in flight
        eng_read(4'd5, model[5]); step();
        eng_read(4'd6, model[6]); step();
        bus.eng_rd_addr_valid_i = 1'b0;
        bus.eng_busy_i          = 1'b0;
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("ar_eng_valid", 128'(bus.eng_row_valid_o), 128'd0);
        chk("ar_owner", 128'(bus.owner_o), 128'(HOST));
        chk("ar_mask", 128'(bus.written_mask_o), 128'd0);
        chk("ar_host_valid", 128'(bus.host_rd_valid_o), 128'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Contents survive reset
        host_read(4'd3, "post_rst_r3");
        host_read(4'd15, "post_rst_r15");
        host_read(4'd4, "post_rst_r4");
        bus.eng_busy_i = 1'b1;
        step();
        eng_read(4'd0, model[0]); step();
        eng_read(4'd8, model[8]); step();
        bus.eng_rd_addr_valid_i = 1'b0;
        bus.eng_busy_i          = 1'b0;
        repeat (6) step();

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lu_row_store.md
Name: lu_row_store

Overview:
- Row-organised complex matrix store that sits on the engine side of the LU engine.
- Serves pipelined, address-tagged row reads and accepts row write-backs from the engine.
- Gives a host port for matrix load and unload while the engine is idle.
- An ownership state machine arbitrates between the host and the engine.

Parameters:
- SIZE, 16: rows per matrix and elements per row.
- ELEM_W, 128: bits per complex element, packed {imag[63:0], real[63:0]}.
- RD_LAT, 2: engine read latency in cycles, from request cycle to response cycle; legal range 1..4.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- eng_busy_i  in  1  engine busy; the engine owns the store while high
- eng_rd_addr_i  in  $clog2(SIZE)  engine read address
- eng_rd_addr_valid_i  in  1  engine read request; no ready, accepted every cycle in ENGINE
- eng_row_o  out  SIZE*ELEM_W  read row data
- eng_row_addr_o  out  $clog2(SIZE)  tag, the address this row was read from
- eng_row_valid_o  out  1  read response valid
- eng_wr_row_i  in  SIZE*ELEM_W  write-back row
- eng_wr_addr_i  in  $clog2(SIZE)  write-back address
- eng_wr_valid_i  in  1  write-back valid
- eng_wr_ready_o  out  1  write-back ready
- host_wr_row_i  in  SIZE*ELEM_W  host load row
- host_wr_addr_i  in  $clog2(SIZE)  host load address
- host_wr_valid_i  in  1  host load valid
- host_wr_ready_o  out  1  host load ready
- host_rd_addr_i  in  $clog2(SIZE)  host unload address
- host_rd_req_valid_i  in  1  host unload request
- host_rd_req_ready_o  out  1  host unload request ready
- host_rd_row_o  out  SIZE*ELEM_W  host unload data
- host_rd_valid_o  out  1  host unload data valid
- host_rd_ready_i  in  1  host unload data ready
- owner_o  out  2  current owner state, encoded as row_owner_t
- written_mask_o  out  SIZE  rows written by the engine since it last took ownership

Behaviour:
- Reset (asynchronous, active-low):
  - owner goes to HOST; all pipeline valids, host_rd_valid_o, eng_row_valid_o and written_mask_o clear to 0; eng_row_addr_o resets to 0.
  - Array contents are not reset.
  - Reset asserted mid-operation drops in-flight reads and writes with no response.
- Owner FSM, row_owner_t = {HOST, ENGINE, DRAIN}:
  - HOST -> ENGINE when eng_busy_i=1 and no host read is outstanding. written_mask_o clears in that same cycle.
  - ENGINE -> DRAIN when eng_busy_i=0.
  - DRAIN -> HOST when the read pipeline holds no valid entry.
  - DRAIN -> ENGINE when eng_busy_i=1 again.
- Readiness by state:
  - host_wr_ready_o = (owner==HOST).
  - host_rd_req_ready_o = (owner==HOST) & no host read outstanding.
  - eng_wr_ready_o = (owner==ENGINE).
  - Engine reads are sampled only in ENGINE; requests in other states are ignored.
- Engine read pipeline:
  - A request in cycle t produces eng_row_valid_o=1 in cycle t+RD_LAT, with eng_row_addr_o equal to the requested address.
  - Back-to-back requests give one response per cycle, in order.
  - eng_row_o and eng_row_addr_o hold their value when eng_row_valid_o=0.
  - Array data is captured at issue.
  - Same-cycle bypass: if an engine write to the same address is accepted in the issue cycle, the response carries the write data.
  - Writes after the issue cycle are not reflected in that response.
- Engine write:
  - Accepted on eng_wr_valid_i & eng_wr_ready_o.
  - The array updates at the clock edge and written_mask_o[addr] sets.
  - A repeated write to the same address overwrites; the mask stays 1.
- Host read:
  - Single outstanding request.
  - Data appears 1 cycle after acceptance and holds until host_rd_ready_i.
  - host_rd_valid_o falls the cycle after the handshake.
- Host write: accepted on handshake; the array updates at the edge.
- Out-of-range addresses (addr >= SIZE, only possible when SIZE is not a power of 2): reads return all-zero data with the correct tag; writes are dropped but still handshaken.
- Simultaneous events:
  - Engine write and engine read to the same address in one cycle: the write wins (bypass above).
  - Host write and the eng_busy_i rise in one cycle: the host write completes, and the owner changes on the same edge.

Decomposition:
- Package lu_pkg holds:
  - ELEM_W_DEFAULT
  - row_owner_t enum, 2 bits
  - elem_t, logic [127:0]
  - ONE_C constant {64'b0, 64'h3ff0000000000000}
- Sub-module row_read_pipe:
  - Parameterised by RD_LAT, SIZE and ELEM_W.
  - Shift stages of {valid, addr, row}; no stall input.
  - Reports busy_o as the OR of the stage valids, used for the DRAIN exit.

Test Plan:
- Load and unload: host writes row 3 with element i = i+1 for all i, then requests address 3 → host_rd_valid_o=1 one cycle later, data matches, holds until host_rd_ready_i.
- Streaming read, RD_LAT=2: in ENGINE, requests for addresses 5,6,7 in consecutive cycles → valid responses tagged 5,6,7 at cycles t+2, t+3, t+4 with the loaded data.
- Bypass: same cycle, engine write of 0xAA..A to address 4 and read of address 4 → response carries 0xAA..A; written_mask_o = 16'h0010.
- Ownership: host_wr_valid_i held high while eng_busy_i=1 → host_wr_ready_o=0 and the array is unchanged. Drop eng_busy_i with 2 reads in flight → owner_o=DRAIN for 2 cycles, both responses delivered, then HOST.
- Reset mid-stream: assert rst_ni=0 asynchronously with 2 reads in flight → eng_row_valid_o=0 immediately, owner_o=HOST, written_mask_o=0. After release, previously loaded rows still read back correctly.
